// File: rtl/wvb_frame_reader.sv
// wvb_frame_reader: drains one waveform (header FIFO + sample RAM) into a 16-bit framed, valid/ready word stream.
// Ports: clk, rst (async, active high), en (allow new frame);
//   hdr_data_in/hdr_empty/hdr_rdreq : FWFT header FIFO {flags, ltc, stop_addr, start_addr};
//   wvb_data_in/wvb_rdreq/wvb_rddone : sample RAM read (data one cycle after rdreq) and space release;
//   dout/dout_valid/dout_ready : framed output stream; busy : frame in progress; frame_cnt : completed frames.
// Optional: define WVB_FRAME_READER_CRC_EN to append a CRC-16-CCITT word to every frame.
module wvb_frame_reader #(
  parameter int P_DATA_WIDTH = 22,
  parameter int P_ADR_WIDTH = 12,
  parameter int P_HDR_WIDTH = 80,
  parameter int P_LTC_WIDTH = 49
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [P_HDR_WIDTH-1:0]  hdr_data_in,
  input  logic                    hdr_empty,
  output logic                    hdr_rdreq,
  input  logic [P_DATA_WIDTH-1:0] wvb_data_in,
  output logic                    wvb_rdreq,
  output logic                    wvb_rddone,
  output logic [15:0]             dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    busy,
  output logic [15:0]             frame_cnt
);
  localparam int AW = P_ADR_WIDTH;
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_RDREQ, S_WAIT, S_SHI, S_SLO, S_CRC, S_DONE} state_t;
  state_t state, state_nx;
  logic [AW:0] nsamp, rem, nsamp_in;
  logic [AW-1:0] span;
  logic [P_LTC_WIDTH-1:0] ltc;
  logic [6:0] flags;
  logic [P_DATA_WIDTH-1:0] sample;
  logic [2:0] widx;
  logic [15:0] hdr_word;
  logic start, xfer;
  assign start = state == S_IDLE && en && !hdr_empty;
  assign xfer = dout_valid && dout_ready;
  // stop - start wraps modulo the buffer size; equal addresses mean one sample
  assign span = hdr_data_in[12 +: AW] - hdr_data_in[0 +: AW];
  assign nsamp_in = {1'b0, span} + (AW+1)'(1);
  assign busy = state != S_IDLE;
  assign hdr_word = widx == 3'd0 ? {3'b100, 13'(nsamp)} :
                    widx == 3'd1 ? {15'b0, ltc[48]} :
                    widx == 3'd2 ? ltc[47:32] :
                    widx == 3'd3 ? ltc[31:16] :
                    widx == 3'd4 ? ltc[15:0] : {9'b0, flags};
`ifdef WVB_FRAME_READER_CRC_EN
  logic [15:0] crc;
  function automatic logic [15:0] crc16(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    return r;
  endfunction
  // the CRC word itself is not folded into the accumulator
  always_ff @(posedge clk or posedge rst)
    if (rst) crc <= 16'hFFFF;
    else if (start) crc <= 16'hFFFF;
    else if (xfer && state != S_CRC) crc <= crc16(crc, dout);
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    dout_valid = 1'b0;
    dout = 16'h0000;
    wvb_rdreq = 1'b0;
    hdr_rdreq = 1'b0;
    wvb_rddone = 1'b0;
    case (state)
      S_IDLE: state_nx = start ? S_HDR : S_IDLE;
      S_HDR: begin
        dout_valid = 1'b1;
        dout = hdr_word;
        state_nx = xfer && widx == 3'd5 ? S_RDREQ : S_HDR;
      end
      S_RDREQ: begin
        wvb_rdreq = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT: state_nx = S_SHI;
      S_SHI: begin
        dout_valid = 1'b1;
        dout = 16'(sample >> 16);
        state_nx = xfer ? S_SLO : S_SHI;
      end
      S_SLO: begin
        dout_valid = 1'b1;
        dout = sample[15:0];
`ifdef WVB_FRAME_READER_CRC_EN
        state_nx = !xfer ? S_SLO : rem == (AW+1)'(1) ? S_CRC : S_RDREQ;
`else
        state_nx = !xfer ? S_SLO : rem == (AW+1)'(1) ? S_DONE : S_RDREQ;
`endif
      end
      S_CRC: begin
`ifdef WVB_FRAME_READER_CRC_EN
        dout_valid = 1'b1;
        dout = crc;
        state_nx = xfer ? S_DONE : S_CRC;
`else
        state_nx = S_IDLE;
`endif
      end
      S_DONE: begin
        hdr_rdreq = 1'b1;
        wvb_rddone = 1'b1;
        state_nx = S_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      nsamp <= '0;
      rem <= '0;
      ltc <= '0;
      flags <= '0;
      sample <= '0;
      widx <= '0;
      frame_cnt <= '0;
    end else begin
      if (start) begin
        nsamp <= nsamp_in;
        rem <= nsamp_in;
        ltc <= hdr_data_in[24 +: P_LTC_WIDTH];
        flags <= hdr_data_in[73 +: 7];
        widx <= '0;
      end
      if (state == S_HDR && xfer) widx <= widx + 3'd1;
      if (state == S_WAIT) sample <= wvb_data_in;
      if (state == S_SLO && xfer) rem <= rem - (AW+1)'(1);
      if (state == S_DONE) frame_cnt <= frame_cnt + 16'd1;
    end
endmodule

// File: tb/tb_wvb_frame_reader.sv
// tb_wvb_frame_reader: randomized self-checking bench with FIFO/RAM models and a frame-level reference model.
module tb_wvb_frame_reader;
  logic clk = 0, rst = 1, en = 0, hdr_empty = 1, dout_ready = 0;
  logic hdr_rdreq, wvb_rdreq, wvb_rddone, dout_valid, busy;
  logic [79:0] hdr_data_in = '0;
  logic [21:0] wvb_data_in = '0;
  logic [15:0] dout, frame_cnt;
  int errors = 0, checks = 0, exp_frames = 0;
  wvb_frame_reader dut (
    .clk(clk), .rst(rst), .en(en), .hdr_data_in(hdr_data_in), .hdr_empty(hdr_empty),
    .hdr_rdreq(hdr_rdreq), .wvb_data_in(wvb_data_in), .wvb_rdreq(wvb_rdreq),
    .wvb_rddone(wvb_rddone), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  logic [21:0] mem [4096];
  logic [11:0] rd_addr = 0, ld_addr = 0;
  logic ld = 0;
  always @(posedge clk)
    if (wvb_rdreq) begin
      wvb_data_in <= mem[rd_addr];
      rd_addr <= rd_addr + 12'd1;
    end else if (ld) rd_addr <= ld_addr;
  logic [79:0] hq[$];
  task automatic refresh_hdr();
    hdr_empty = hq.size() == 0;
    hdr_data_in = hq.size() != 0 ? hq[0] : '0;
  endtask
  always @(negedge clk)
    if (hdr_rdreq && hq.size() != 0) begin
      hq.delete(0);
      refresh_hdr();
    end
  logic bp_on = 0, rdy = 1;
  always @(posedge clk) begin
    #2;
    dout_ready = bp_on ? 1'($urandom_range(0, 1)) : rdy;
  end
  logic [15:0] got[$], exp[$];
  int nrdreq = 0, nhdrrd = 0, nrddone = 0, both_err = 0, pair_err = 0, stall_err = 0;
  logic prev_stall = 0;
  logic [15:0] prev_dout = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (dout_valid && dout_ready) got.push_back(dout);
      if (wvb_rdreq) nrdreq++;
      if (hdr_rdreq) nhdrrd++;
      if (wvb_rddone) nrddone++;
      if (hdr_rdreq && wvb_rdreq) both_err++;
      if (hdr_rdreq !== wvb_rddone) pair_err++;
      if (prev_stall && (!dout_valid || dout !== prev_dout)) stall_err++;
    end
    prev_stall = !rst && dout_valid && !dout_ready;
    prev_dout = dout;
  end
  task automatic clear_mon();
    got.delete();
    exp.delete();
    nrdreq = 0; nhdrrd = 0; nrddone = 0; both_err = 0; pair_err = 0; stall_err = 0;
  endtask
  task automatic push_hdr(input logic [11:0] s, input logic [11:0] e, input logic [48:0] l, input logic [6:0] f);
    hq.push_back({f, l, e, s});
    refresh_hdr();
  endtask
  task automatic load_addr(input logic [11:0] a);
    ld_addr = a;
    ld = 1;
    @(posedge clk); #1;
    ld = 0;
  endtask
  // reference frame: header words, two words per sample, optional CRC-16-CCITT over the frame
  task automatic build_exp(input logic [11:0] s, input logic [11:0] e, input logic [48:0] l, input logic [6:0] f);
    int n, from;
    logic [21:0] w;
    logic [15:0] c;
    from = exp.size();
    n = ((int'(e) - int'(s) + 4096) % 4096) + 1;
    exp.push_back(16'h8000 | 16'(n));
    exp.push_back({15'b0, l[48]});
    exp.push_back(l[47:32]);
    exp.push_back(l[31:16]);
    exp.push_back(l[15:0]);
    exp.push_back({9'b0, f});
    for (int i = 0; i < n; i++) begin
      w = mem[(int'(s) + i) % 4096];
      exp.push_back(16'(w / 65536));
      exp.push_back(16'(w % 65536));
    end
`ifdef WVB_FRAME_READER_CRC_EN
    c = 16'hFFFF;
    for (int i = from; i < exp.size(); i++)
      for (int b = 15; b >= 0; b--) begin
        logic fb;
        fb = c[15] ^ exp[i][b];
        c = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    exp.push_back(c);
`else
    c = 16'(from);
    if (c === 16'hxxxx) $display("unreachable");
`endif
  endtask
  function automatic int first_diff();
    int m;
    m = got.size() > exp.size() ? got.size() : exp.size();
    for (int i = 0; i < m; i++)
      if (i >= got.size() || i >= exp.size() || got[i] !== exp[i]) return i;
    return -1;
  endfunction
  task automatic wait_done(input int target, input int budget);
    int c;
    c = 0;
    while (nrddone < target && c < budget) begin
      @(posedge clk);
      c++;
    end
    @(posedge clk); #1;
    checks++;
    if (nrddone < target) begin
      errors++;
      $display("FAIL done_timeout: rddone pulses=%0d required=%0d", nrddone, target);
    end
  endtask
  task automatic test_reset();
    rst = 1;
    en = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({dout_valid, busy, dout} !== 18'h0) begin
      errors++;
      $display("FAIL reset_out: valid=%b busy=%b dout=%h required 0", dout_valid, busy, dout);
    end
    checks++;
    if ({hdr_rdreq, wvb_rdreq, wvb_rddone} !== 3'b000) begin
      errors++;
      $display("FAIL reset_req: hdr_rdreq/wvb_rdreq/wvb_rddone=%b%b%b required 000", hdr_rdreq, wvb_rdreq, wvb_rddone);
    end
    checks++;
    if (frame_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_cnt: frame_cnt=%0d required 0", frame_cnt);
    end
    rst = 0;
    exp_frames = 0;
    en = 1;
    @(posedge clk); #1;
  endtask
  task automatic test_single();
    logic [15:0] lit [8];
    lit = '{16'h8001, 16'h0001, 16'h0000, 16'h0000, 16'h0005, 16'h0003, 16'h002A, 16'hBCDE};
    mem[12'h010] = 22'h2ABCDE;
    load_addr(12'h010);
    clear_mon();
    push_hdr(12'h010, 12'h010, 49'h1_0000_0000_0005, 7'h03);
    build_exp(12'h010, 12'h010, 49'h1_0000_0000_0005, 7'h03);
    @(negedge clk);
    checks++;
    if (dout_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_idle: valid=%b busy=%b required 0 0", dout_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (dout_valid !== 1'b1 || dout !== 16'h8001) begin
      errors++;
      $display("FAIL start_latency: valid=%b dout=%h required 1 8001", dout_valid, dout);
    end
    wait_done(1, 200);
    exp_frames++;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got.size() <= i || got[i] !== lit[i]) begin
        errors++;
        $display("FAIL single_word%0d: got=%h required=%h", i, got.size() > i ? got[i] : 16'hxxxx, lit[i]);
      end
    end
    checks++;
`ifdef WVB_FRAME_READER_CRC_EN
    if (got.size() != 9 || first_diff() != -1) begin
      errors++;
      $display("FAIL single_crc: words=%0d last=%h required 9 words last=%h", got.size(), got.size() ? got[got.size()-1] : 16'h0, exp[8]);
    end
`else
    if (got.size() != 8) begin
      errors++;
      $display("FAIL single_len: words=%0d required 8", got.size());
    end
`endif
    checks++;
    if (nhdrrd != 1 || nrddone != 1 || pair_err != 0) begin
      errors++;
      $display("FAIL single_release: hdr_rdreq=%0d rddone=%0d unpaired=%0d required 1 1 0", nhdrrd, nrddone, pair_err);
    end
    checks++;
    if (frame_cnt !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL single_cnt: frame_cnt=%0d required %0d", frame_cnt, exp_frames);
    end
  endtask
  task automatic test_wrap();
    load_addr(12'hFFE);
    clear_mon();
    push_hdr(12'hFFE, 12'h001, 49'(64'h1234_5678_9ABC), 7'h55);
    build_exp(12'hFFE, 12'h001, 49'(64'h1234_5678_9ABC), 7'h55);
    wait_done(1, 200);
    exp_frames++;
    checks++;
    if (got.size() == 0 || got[0] !== 16'h8004) begin
      errors++;
      $display("FAIL wrap_h0: h0=%h required 8004", got.size() ? got[0] : 16'h0);
    end
    checks++;
    if (nrdreq != 4) begin
      errors++;
      $display("FAIL wrap_rdreq: pulses=%0d required 4", nrdreq);
    end
    checks++;
`ifdef WVB_FRAME_READER_CRC_EN
    if (got.size() != 15) begin
`else
    if (got.size() != 14) begin
`endif
      errors++;
      $display("FAIL wrap_len: words=%0d required %0d", got.size(), exp.size());
    end
    checks++;
    if (first_diff() != -1) begin
      errors++;
      $display("FAIL wrap_words: first difference at word %0d of %0d", first_diff(), exp.size());
    end
  endtask
  task automatic test_backpressure();
    logic [11:0] s;
    logic [48:0] l;
    s = 12'($urandom);
    l = 49'({$urandom, $urandom});
    load_addr(s);
    clear_mon();
    bp_on = 1;
    push_hdr(s, s + 12'd99, l, 7'($urandom));
    build_exp(s, s + 12'd99, l, hq[0][79:73]);
    wait_done(1, 4000);
    bp_on = 0;
    exp_frames++;
    checks++;
    if (first_diff() != -1) begin
      errors++;
      $display("FAIL bp_words: first difference at word %0d, got %0d words required %0d", first_diff(), got.size(), exp.size());
    end
    checks++;
    if (stall_err != 0) begin
      errors++;
      $display("FAIL bp_stable: stall violations=%0d required 0", stall_err);
    end
    checks++;
    if (nrdreq != 100 || both_err != 0) begin
      errors++;
      $display("FAIL bp_rdreq: pulses=%0d overlap=%0d required 100 0", nrdreq, both_err);
    end
  endtask
  task automatic test_random();
    logic [11:0] s, e;
    logic [48:0] l;
    logic [6:0] f;
    for (int k = 0; k < 4; k++) begin
      s = 12'($urandom);
      e = s + 12'($urandom_range(0, 19));
      l = 49'({$urandom, $urandom});
      f = 7'($urandom);
      load_addr(s);
      clear_mon();
      bp_on = 1'($urandom_range(0, 1));
      push_hdr(s, e, l, f);
      build_exp(s, e, l, f);
      wait_done(1, 1000);
      bp_on = 0;
      exp_frames++;
      checks++;
      if (first_diff() != -1 || stall_err != 0) begin
        errors++;
        $display("FAIL random%0d_words: first difference at %0d, stalls=%0d, required none", k, first_diff(), stall_err);
      end
    end
    checks++;
    if (frame_cnt !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL random_cnt: frame_cnt=%0d required %0d", frame_cnt, exp_frames);
    end
  endtask
  task automatic test_back_to_back();
    logic [11:0] s1, s2;
    s1 = 12'($urandom);
    s2 = s1 + 12'd5;
    load_addr(s1);
    clear_mon();
    push_hdr(s1, s1 + 12'd4, 49'h0_0000_0000_0ABC, 7'h11);
    push_hdr(s2, s2 + 12'd2, 49'h1_FFFF_FFFF_FFFF, 7'h7F);
    build_exp(s1, s1 + 12'd4, 49'h0_0000_0000_0ABC, 7'h11);
    build_exp(s2, s2 + 12'd2, 49'h1_FFFF_FFFF_FFFF, 7'h7F);
    wait_done(2, 400);
    exp_frames += 2;
    checks++;
    if (first_diff() != -1) begin
      errors++;
      $display("FAIL b2b_words: first difference at %0d, got %0d words required %0d", first_diff(), got.size(), exp.size());
    end
    checks++;
    if (nhdrrd != 2 || both_err != 0 || pair_err != 0 || nrdreq != 8) begin
      errors++;
      $display("FAIL b2b_ctrl: hdr_rdreq=%0d overlap=%0d unpaired=%0d rdreq=%0d required 2 0 0 8", nhdrrd, both_err, pair_err, nrdreq);
    end
    checks++;
    if (frame_cnt !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL b2b_cnt: frame_cnt=%0d required %0d", frame_cnt, exp_frames);
    end
  endtask
  task automatic test_reset_mid();
    logic [11:0] s;
    int c;
    s = 12'($urandom);
    load_addr(s);
    clear_mon();
    push_hdr(s, s + 12'd9, 49'h0_1111_2222_3333, 7'h01);
    c = 0;
    while (got.size() < 12 && c < 200) begin
      @(negedge clk);
      c++;
    end
    #1;
    rst = 1;
    #1;
    checks++;
    if ({dout_valid, busy, hdr_rdreq, wvb_rdreq, wvb_rddone, dout, frame_cnt} !== 37'h0) begin
      errors++;
      $display("FAIL midrst_out: valid=%b busy=%b reqs=%b%b%b dout=%h cnt=%0d required all 0", dout_valid, busy, hdr_rdreq, wvb_rdreq, wvb_rddone, dout, frame_cnt);
    end
    checks++;
    if (nrddone != 0 || got.size() < 12) begin
      errors++;
      $display("FAIL midrst_rddone: rddone=%0d words=%0d required 0 and >=12", nrddone, got.size());
    end
    @(posedge clk); #1;
    rst = 0;
    exp_frames = 0;
    hq.delete();
    refresh_hdr();
    s = 12'($urandom);
    load_addr(s);
    clear_mon();
    push_hdr(s, s + 12'd2, 49'h0_0000_0000_0042, 7'h22);
    build_exp(s, s + 12'd2, 49'h0_0000_0000_0042, 7'h22);
    wait_done(1, 200);
    exp_frames++;
    checks++;
    if (got.size() == 0 || got[0] !== 16'h8003 || first_diff() != -1) begin
      errors++;
      $display("FAIL midrst_next: h0=%h diff at %0d required 8003 and no difference", got.size() ? got[0] : 16'h0, first_diff());
    end
  endtask
  task automatic test_en_gating();
    logic [11:0] s;
    int c;
    s = 12'($urandom);
    en = 0;
    load_addr(s);
    clear_mon();
    push_hdr(s, s + 12'd3, 49'h0_0000_0000_0777, 7'h44);
    build_exp(s, s + 12'd3, 49'h0_0000_0000_0777, 7'h44);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || got.size() != 0 || nrdreq != 0 || nhdrrd != 0) begin
      errors++;
      $display("FAIL en_off: busy=%b words=%0d rdreq=%0d hdr_rdreq=%0d required 0 0 0 0", busy, got.size(), nrdreq, nhdrrd);
    end
    en = 1;
    c = 0;
    while (got.size() < 3 && c < 100) begin
      @(posedge clk);
      c++;
    end
    #1;
    en = 0;
    wait_done(1, 200);
    exp_frames++;
    checks++;
    if (first_diff() != -1) begin
      errors++;
      $display("FAIL en_drop_words: first difference at %0d, got %0d required %0d", first_diff(), got.size(), exp.size());
    end
    en = 1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || hdr_empty !== 1'b1 || got.size() != exp.size() || frame_cnt !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL empty_idle: busy=%b empty=%b words=%0d cnt=%0d required 0 1 %0d %0d", busy, hdr_empty, got.size(), frame_cnt, exp.size(), exp_frames);
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 22'($urandom);
    test_reset();
    test_single();
    test_wrap();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_en_gating();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wvb_frame_reader.md
# wvb_frame_reader

Drains one waveform at a time from the waveform buffer's reader interface (header FIFO plus sample RAM) and serialises it into a 16-bit framed word stream with valid/ready backpressure. The block sits between the waveform acquisition block and the downstream readout path (DPRAM loader or serial link).

It pops the header, reads exactly the sample span that header describes, and then releases the buffer space.

## Interface

**Parameters**
- `P_DATA_WIDTH`, 22: sample word width. Range 17–32.
- `P_ADR_WIDTH`, 12: buffer address width. Must be ≤ 12.
- `P_HDR_WIDTH`, 80: header width.
- `P_LTC_WIDTH`, 49: local time counter width.

**Ports**
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  permits starting a new frame.
- `hdr_data_in`  in  P_HDR_WIDTH  header, first-word-fall-through. Fields:
  - `[11:0]` start_addr
  - `[23:12]` stop_addr
  - `[72:24]` ltc
  - `[79:73]` flags
- `hdr_empty`  in  1  header FIFO empty.
- `hdr_rdreq`  out  1  pops one header.
- `wvb_data_in`  in  P_DATA_WIDTH  sample; valid exactly 1 cycle after `wvb_rdreq`.
- `wvb_rdreq`  out  1  reads next sample; the buffer advances its own read address.
- `wvb_rddone`  out  1  releases the current waveform's buffer space.
- `dout`  out  16  frame word.
- `dout_valid`  out  1  `dout` is valid.
- `dout_ready`  in  1  downstream accepts the word.
- `busy`  out  1  a frame is in progress.
- `frame_cnt`  out  16  count of completed frames; wraps.

## Operation

**States:** IDLE, HDR, RDREQ, WAIT, SHI, SLO, CRC, DONE.

- **IDLE**
  - When `en` is high and `hdr_empty` is low: latch `hdr_data_in`.
  - Compute nsamp = ((stop_addr − start_addr) mod 2^P_ADR_WIDTH) + 1, width P_ADR_WIDTH+1. Wrap-around is legal; start equal to stop gives nsamp = 1.
  - Go to HDR.
- **HDR**: emits 6 words, advancing only on handshake:
  - H0 = {3'b100, nsamp[12:0]}
  - H1 = {15'b0, ltc[48]}
  - H2 = ltc[47:32]
  - H3 = ltc[31:16]
  - H4 = ltc[15:0]
  - H5 = {9'b0, flags}
  - After H5 is accepted, go to RDREQ.
- **RDREQ**: pulse `wvb_rdreq` for 1 cycle, then go to WAIT.
- **WAIT**: capture `wvb_data_in` into the holding register, then go to SHI.
- **SHI**: emit {zero-extend, sample[P_DATA_WIDTH-1:16]}. On handshake go to SLO.
- **SLO**: emit sample[15:0]. On handshake, decrement the remaining count.
  - Count nonzero: go to RDREQ.
  - Count zero: go to CRC (macro defined) or DONE.
- **CRC**: see Configuration.
- **DONE**
  - Pulse `hdr_rdreq` and `wvb_rddone` together for 1 cycle.
  - Increment `frame_cnt`.
  - Go to IDLE.
- `busy` is high in every state except IDLE.
- Deasserting `en` mid-frame has no effect; the current frame completes. `en` is sampled only in IDLE.
- `hdr_rdreq` and `wvb_rdreq` are never asserted in the same cycle.

## Timing

- **Reset values:** all outputs 0; state IDLE; holding registers 0.
- **Reset mid-frame:** returns to IDLE immediately. No `hdr_rdreq` or `wvb_rddone` is issued; buffer recovery is handled by the shared system reset.
- **Start latency:** `hdr_empty` falls with `en` high at cycle N → H0 appears with `dout_valid` high at cycle N+1.
- **Output handshake:**
  - A word transfers on a cycle where `dout_valid` and `dout_ready` are both high.
  - While `dout_valid` is high and `dout_ready` is low, `dout` is held stable.
  - `dout_valid` is low in RDREQ, WAIT and DONE.
- **Throughput:** 2 words per 4 cycles per sample with `dout_ready` held high.
- **Back-to-back frames:** after DONE, IDLE re-evaluates `hdr_empty` in the next cycle. This gives a gap of ≥ 2 cycles between frames.
- **Frame length:** 6 + 2·nsamp words, plus 1 word when CRC is enabled.

## Configuration

**`WVB_FRAME_READER_CRC_EN`**
- **Defined:**
  - CRC-16-CCITT is accumulated over every emitted word at handshake: poly 0x1021, init 0xFFFF, MSB-first, no reflection, no final XOR.
  - CRC state emits the final CRC as the last word, then goes to DONE.
  - The accumulator re-initialises on IDLE→HDR.
- **Undefined:** no CRC logic; SLO with the last sample goes directly to DONE.

## Test plan

1. **Single sample, no backpressure.** Header start=0x010, stop=0x010, ltc=0x1_0000_0000_0005, flags=0x03; sample 0x2ABCDE.
   - Required words: 0x8001, 0x0001, 0x0000, 0x0000, 0x0005, 0x0003, 0x002A, 0xBCDE.
   - Then `hdr_rdreq` and `wvb_rddone` pulse together for 1 cycle, and `frame_cnt` = 1.
2. **Address wrap.** start=0xFFE, stop=0x001 → H0 = 0x8004, exactly 4 `wvb_rdreq` pulses, 14 words total.
3. **Backpressure.** `dout_ready` toggles on a pseudo-random pattern over a 100-sample waveform → every word appears exactly once, `dout` is stable while stalled, and no extra `wvb_rdreq` is issued.
4. **Reset mid-frame.** Assert `rst` after sample 3 of 10 → all outputs are 0 within the same cycle with no `wvb_rddone`. After release with a new header, the next frame starts with H0.
5. **`en` gating and empty FIFO.** `en`=0 with `hdr_empty`=0 → no activity. `en` dropped mid-frame → the frame completes. `hdr_empty`=1 with `en`=1 → IDLE holds with `busy`=0.
6. **CRC (`WVB_FRAME_READER_CRC_EN` defined).** Test 1 stimulus → the final word equals the CRC-16-CCITT of the 8 preceding words computed by the reference model. Frame length is 9 words.
